// File: rtl/fxp_seq_mul_if.sv
// Operand/result handshake bundle for the sequential fixed-point multiplier.
// master drives operands and result acceptance; slave is the multiplier.
interface fxp_seq_mul_if #(
  parameter int IW = 8,
  parameter int FW = 8
);
  localparam int W = IW + FW;

  logic             in_valid;
  logic             in_ready;
  logic             in_signed;
  logic [W-1:0]     a;
  logic [W-1:0]     b;
  logic             out_valid;
  logic             out_ready;
  logic [2*W-1:0]   prod_full;
  logic [W-1:0]     prod;
  logic             ovf;

  modport master (
    output in_valid, in_signed, a, b, out_ready,
    input  in_ready, out_valid, prod_full, prod, ovf
  );

  modport slave (
    input  in_valid, in_signed, a, b, out_ready,
    output in_ready, out_valid, prod_full, prod, ovf
  );
endinterface

// File: rtl/fxp_seq_mul.sv
// Shift-add IW.FW multiplier, one multiplier bit per clock, signed/unsigned per transaction.
// Yields the exact 2IW.2FW product and a rounded, saturated IW.FW product.
module fxp_seq_mul #(
  parameter int IW         = 8,
  parameter int FW         = 8,
  parameter bit EARLY_EXIT = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  fxp_seq_mul_if.slave bus,
  output logic         busy
);
  localparam int W  = IW + FW;
  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t         state, state_next;
  logic           sign, mode;
  logic [2*W-1:0] mcand, acc;
  logic [W-1:0]   mplier;
  logic [CW-1:0]  cnt;
  logic           run_last;
  logic [W-1:0]   a_mag, b_mag;
  logic [2*W-1:0] full;
  logic [W+IW:0]  rnd;
  logic           ovf_s, ovf_u, ovf_n;
  logic [W-1:0]   prod_n;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next    = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    busy          = 1'b1;
    run_last      = (cnt == CW'(W-1)) || (EARLY_EXIT && (mplier[W-1:1] == '0));
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        busy         = 1'b0;
        if (bus.in_valid) state_next = RUN;
      end
      RUN:  if (run_last) state_next = FIX;
      FIX:  state_next = DONE;
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    a_mag = (bus.in_signed && bus.a[W-1]) ? -bus.a : bus.a;
    b_mag = (bus.in_signed && bus.b[W-1]) ? -bus.b : bus.b;
  end

  // Rounding folded into the shift: floor((x + 2^(FW-1)) / 2^FW) == (x >>> FW) + x[FW-1],
  // evaluated one bit wider than the product so the rounding carry reaches the range test.
  always_comb begin
    full   = sign ? -acc : acc;
    rnd    = {mode & full[2*W-1], full[2*W-1:FW]} + (W+IW+1)'(full[FW-1]);
    ovf_s  = ~((&rnd[W+IW:W-1]) | ~(|rnd[W+IW:W-1]));
    ovf_u  = |rnd[W+IW:W];
    prod_n = rnd[W-1:0];
    if (mode) begin
      ovf_n = ovf_s;
      if (ovf_s) prod_n = rnd[W+IW] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end else begin
      ovf_n = ovf_u;
      if (ovf_u) prod_n = '1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sign          <= 1'b0;
      mode          <= 1'b0;
      mcand         <= '0;
      mplier        <= '0;
      acc           <= '0;
      cnt           <= '0;
      bus.prod_full <= '0;
      bus.prod      <= '0;
      bus.ovf       <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          mode   <= bus.in_signed;
          sign   <= bus.in_signed & (bus.a[W-1] ^ bus.b[W-1]);
          mcand  <= {{W{1'b0}}, a_mag};
          mplier <= b_mag;
          acc    <= '0;
          cnt    <= '0;
        end
        RUN: begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CW'(1);
        end
        FIX: begin
          bus.prod_full <= full;
          bus.prod      <= prod_n;
          bus.ovf       <= ovf_n;
        end
        default: ;
      endcase
    end
  end
endmodule
